// File: rtl/axioma_regpair_pkg.sv
// rtl/axioma_regpair_pkg.sv - shared op codes, states, pair indices and SREG flag positions
package axioma_regpair_pkg;

    typedef enum logic [1:0] {
        OP_MOVW = 2'b00,
        OP_ADIW = 2'b01,
        OP_SBIW = 2'b10,
        OP_WR16 = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WR_LO = 3'd2,
        ST_WR_HI = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    localparam logic [3:0] X_PAIR = 4'd13;
    localparam logic [3:0] Y_PAIR = 4'd14;
    localparam logic [3:0] Z_PAIR = 4'd15;

    // Bit positions inside sreg_flags = {S,V,N,Z,C}
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_S = 4;

    function automatic logic is_arith(input op_e op);
        return (op == OP_ADIW) || (op == OP_SBIW);
    endfunction

endpackage

// File: rtl/axioma_regpair_alu.sv
// rtl/axioma_regpair_alu.sv - 16-bit add/sub of a 6-bit constant with S/V/N/Z/C generation
module axioma_regpair_alu
    import axioma_regpair_pkg::*;
(
    input  logic [15:0] pair_i,
    input  logic [5:0]  k_i,
    input  logic        sub_i,
    output logic [15:0] res_o,
    output logic [4:0]  flags_o
);

    logic rh7;
    logic r15;

    always_comb begin
        res_o   = sub_i ? (pair_i - {10'd0, k_i}) : (pair_i + {10'd0, k_i});
        rh7     = pair_i[15];
        r15     = res_o[15];
        flags_o = '0;
        // Only the top bits matter since K never reaches bit 15
        flags_o[FLAG_C] = sub_i ? (r15 & ~rh7) : (~r15 & rh7);
        flags_o[FLAG_V] = sub_i ? (rh7 & ~r15) : (~rh7 & r15);
        flags_o[FLAG_N] = r15;
        flags_o[FLAG_Z] = (res_o == 16'd0);
        flags_o[FLAG_S] = r15 ^ flags_o[FLAG_V];
    end

endmodule

// File: rtl/axioma_regpair_seq.sv
// rtl/axioma_regpair_seq.sv - register-pair sequencer (MOVW/ADIW/SBIW/WR16); AXIOMA_REGPAIR_PTR_EN enables X/Y/Z pointer writes
module axioma_regpair_seq
    import axioma_regpair_pkg::*;
#(
    parameter int ADIW_MIN_PAIR = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_dst,
    input  logic [3:0]  cmd_src,
    input  logic [15:0] cmd_imm,
    output logic [4:0]  rs1_addr,
    input  logic [7:0]  rs1_data,
    output logic [4:0]  rs2_addr,
    input  logic [7:0]  rs2_data,
    output logic [4:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        rd_write_en,
    output logic [15:0] ptr_data,
    output logic        x_write_en,
    output logic        y_write_en,
    output logic        z_write_en,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [4:0]  sreg_flags,
    output logic        flags_valid
);

    localparam logic [3:0] MIN_PAIR = 4'(ADIW_MIN_PAIR);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [3:0]  dst_q, dst_d;
    logic [3:0]  src_q, src_d;
    logic [5:0]  k_q, k_d;
    logic [15:0] res_q, res_d;
    logic [4:0]  pflags_q, pflags_d;
    logic [4:0]  sreg_q, sreg_d;

    logic [3:0]  rd_pair;
    logic        ptr_hit;
    logic [15:0] alu_res;
    logic [4:0]  alu_flags;

    axioma_regpair_alu u_alu (
        .pair_i  ({rs2_data, rs1_data}),
        .k_i     (k_q),
        .sub_i   (op_q == OP_SBIW),
        .res_o   (alu_res),
        .flags_o (alu_flags)
    );

`ifdef AXIOMA_REGPAIR_PTR_EN
    assign ptr_hit = (dst_q >= X_PAIR);
`else
    assign ptr_hit = 1'b0;
`endif

    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign busy      = (state_q != ST_IDLE);
    assign rd_pair   = (op_q == OP_MOVW) ? src_q : dst_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MOVW;
            dst_q    <= '0;
            src_q    <= '0;
            k_q      <= '0;
            res_q    <= '0;
            pflags_q <= '0;
            sreg_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            src_q    <= src_d;
            k_q      <= k_d;
            res_q    <= res_d;
            pflags_q <= pflags_d;
            sreg_q   <= sreg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dst_d       = dst_q;
        src_d       = src_q;
        k_d         = k_q;
        res_d       = res_q;
        pflags_d    = pflags_q;
        sreg_d      = sreg_q;
        rs1_addr    = '0;
        rs2_addr    = '0;
        rd_addr     = '0;
        rd_data     = '0;
        rd_write_en = 1'b0;
        ptr_data    = '0;
        x_write_en  = 1'b0;
        y_write_en  = 1'b0;
        z_write_en  = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        flags_valid = 1'b0;
        sreg_flags  = sreg_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d  = op_e'(cmd_op);
                    dst_d = cmd_dst;
                    src_d = cmd_src;
                    k_d   = cmd_imm[5:0];
                    if (is_arith(op_e'(cmd_op)) && (cmd_dst < MIN_PAIR)) begin
                        state_d = ST_ERR;
                    end else if (op_e'(cmd_op) == OP_WR16) begin
                        res_d   = cmd_imm;
                        state_d = ST_WR_LO;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                rs1_addr = {rd_pair, 1'b0};
                rs2_addr = {rd_pair, 1'b1};
                res_d    = (op_q == OP_MOVW) ? {rs2_data, rs1_data} : alu_res;
                pflags_d = alu_flags;
                state_d  = ST_WR_LO;
            end
            ST_WR_LO: begin
                if (ptr_hit) begin
                    // Whole pair goes out through the pointer port in one cycle
                    ptr_data   = res_q;
                    x_write_en = (dst_q == X_PAIR);
                    y_write_en = (dst_q == Y_PAIR);
                    z_write_en = (dst_q == Z_PAIR);
                    done       = 1'b1;
                    if (is_arith(op_q)) begin
                        flags_valid = 1'b1;
                        sreg_flags  = pflags_q;
                        sreg_d      = pflags_q;
                    end
                    state_d = ST_IDLE;
                end else begin
                    rd_write_en = 1'b1;
                    rd_addr     = {dst_q, 1'b0};
                    rd_data     = res_q[7:0];
                    state_d     = ST_WR_HI;
                end
            end
            ST_WR_HI: begin
                rd_write_en = 1'b1;
                rd_addr     = {dst_q, 1'b1};
                rd_data     = res_q[15:8];
                done        = 1'b1;
                if (is_arith(op_q)) begin
                    flags_valid = 1'b1;
                    sreg_flags  = pflags_q;
                    sreg_d      = pflags_q;
                end
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                err     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axioma_regpair_seq.sv
// tb/tb_axioma_regpair_seq.sv - directed self-checking bench for axioma_regpair_seq
module tb_axioma_regpair_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_dst;
    logic [3:0]  cmd_src;
    logic [15:0] cmd_imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [7:0]  rs1_data, rs2_data, rd_data;
    logic        rd_write_en;
    logic [15:0] ptr_data;
    logic        x_write_en, y_write_en, z_write_en;
    logic        busy, done, err, flags_valid;
    logic [4:0]  sreg_flags;

    logic [7:0]  rf [32];
    logic        pl_en;
    logic [3:0]  pl_pair;
    logic [15:0] pl_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axioma_regpair_seq dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_write_en(rd_write_en),
        .ptr_data(ptr_data), .x_write_en(x_write_en), .y_write_en(y_write_en),
        .z_write_en(z_write_en), .busy(busy), .done(done), .err(err),
        .sreg_flags(sreg_flags), .flags_valid(flags_valid)
    );

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    always @(posedge clk) begin
        if (rd_write_en) rf[rd_addr] <= rd_data;
        else if (pl_en) begin
            rf[{pl_pair, 1'b0}] <= pl_val[7:0];
            rf[{pl_pair, 1'b1}] <= pl_val[15:8];
        end
    end

    task automatic preload(input logic [3:0] pair, input logic [15:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_pair = pair; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Offers a command for one edge; returns at the negedge of cycle T+1
    task automatic send(input logic [1:0] op, input logic [3:0] dst, input logic [3:0] src, input logic [15:0] imm);
        @(negedge clk);
        cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm; cmd_valid = 1'b1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL send_ready: got %b exp 1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dst = '0; cmd_src = '0; cmd_imm = '0;
        pl_en = 1'b0; pl_pair = '0; pl_val = '0;
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", cmd_ready); end
        checks++; if ({busy, done, err, flags_valid, rd_write_en} !== 5'b0) begin errors++; $display("FAIL rst_strobes: got %b exp 0", {busy, done, err, flags_valid, rd_write_en}); end
        checks++; if ({rd_addr, rd_data, rs1_addr, rs2_addr, ptr_data, sreg_flags} !== '0) begin errors++; $display("FAIL rst_data: got %h exp 0", {rd_addr, rd_data, rs1_addr, rs2_addr, ptr_data, sreg_flags}); end
        reset = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b exp 1", cmd_ready); end
    endtask

    task automatic test_adiw_basic;
        preload(4'd12, 16'h00FF);
        send(2'b01, 4'd12, 4'd0, 16'd1);
        checks++; if ({busy, rs1_addr, rs2_addr} !== {1'b1, 5'd24, 5'd25}) begin errors++; $display("FAIL adiw_read: got %h exp %h", {busy, rs1_addr, rs2_addr}, {1'b1, 5'd24, 5'd25}); end
        @(negedge clk);
        checks++; if ({rd_write_en, rd_addr, rd_data, done} !== {1'b1, 5'd24, 8'h00, 1'b0}) begin errors++; $display("FAIL adiw_lo: got %h exp %h", {rd_write_en, rd_addr, rd_data, done}, {1'b1, 5'd24, 8'h00, 1'b0}); end
        @(negedge clk);
        checks++; if ({rd_write_en, rd_addr, rd_data, done, flags_valid} !== {1'b1, 5'd25, 8'h01, 1'b1, 1'b1}) begin errors++; $display("FAIL adiw_hi: got %h exp %h", {rd_write_en, rd_addr, rd_data, done, flags_valid}, {1'b1, 5'd25, 8'h01, 1'b1, 1'b1}); end
        checks++; if (sreg_flags !== 5'b00000) begin errors++; $display("FAIL adiw_flags: got %b exp 00000", sreg_flags); end
        @(negedge clk);
        checks++; if ({rf[25], rf[24]} !== 16'h0100) begin errors++; $display("FAIL adiw_rf: got %h exp 0100", {rf[25], rf[24]}); end
    endtask

    task automatic test_adiw_wrap;
        preload(4'd13, 16'hFFFF);
        send(2'b01, 4'd13, 4'd0, 16'd1);
        @(negedge clk);
`ifdef AXIOMA_REGPAIR_PTR_EN
        checks++; if ({x_write_en, y_write_en, z_write_en, rd_write_en, done, flags_valid} !== 6'b100011) begin errors++; $display("FAIL wrap_ptr: got %b exp 100011", {x_write_en, y_write_en, z_write_en, rd_write_en, done, flags_valid}); end
        checks++; if (ptr_data !== 16'h0000) begin errors++; $display("FAIL wrap_ptr_data: got %h exp 0000", ptr_data); end
`else
        checks++; if ({rd_write_en, rd_addr, rd_data, done, x_write_en} !== {1'b1, 5'd26, 8'h00, 1'b0, 1'b0}) begin errors++; $display("FAIL wrap_lo: got %h exp %h", {rd_write_en, rd_addr, rd_data, done, x_write_en}, {1'b1, 5'd26, 8'h00, 1'b0, 1'b0}); end
        @(negedge clk);
        checks++; if ({rd_write_en, rd_addr, rd_data, done, flags_valid} !== {1'b1, 5'd27, 8'h00, 1'b1, 1'b1}) begin errors++; $display("FAIL wrap_hi: got %h exp %h", {rd_write_en, rd_addr, rd_data, done, flags_valid}, {1'b1, 5'd27, 8'h00, 1'b1, 1'b1}); end
`endif
        checks++; if (sreg_flags !== 5'b00011) begin errors++; $display("FAIL wrap_flags: got %b exp 00011", sreg_flags); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %b exp 1", cmd_ready); end
    endtask

    task automatic test_wr16;
        send(2'b11, 4'd0, 4'd0, 16'h1234);
        checks++; if ({rd_write_en, rd_addr, rd_data, done} !== {1'b1, 5'd0, 8'h34, 1'b0}) begin errors++; $display("FAIL wr16_lo: got %h exp %h", {rd_write_en, rd_addr, rd_data, done}, {1'b1, 5'd0, 8'h34, 1'b0}); end
        @(negedge clk);
        checks++; if ({rd_write_en, rd_addr, rd_data, done, flags_valid} !== {1'b1, 5'd1, 8'h12, 1'b1, 1'b0}) begin errors++; $display("FAIL wr16_hi: got %h exp %h", {rd_write_en, rd_addr, rd_data, done, flags_valid}, {1'b1, 5'd1, 8'h12, 1'b1, 1'b0}); end
        checks++; if (sreg_flags !== 5'b00011) begin errors++; $display("FAIL wr16_flags_held: got %b exp 00011", sreg_flags); end
        @(negedge clk);
        checks++; if ({rf[1], rf[0]} !== 16'h1234) begin errors++; $display("FAIL wr16_rf: got %h exp 1234", {rf[1], rf[0]}); end
    endtask

    task automatic test_sbiw_movw;
        preload(4'd15, 16'h8000);
        send(2'b10, 4'd15, 4'd0, 16'd1);
        @(negedge clk);
`ifdef AXIOMA_REGPAIR_PTR_EN
        checks++; if ({x_write_en, y_write_en, z_write_en, rd_write_en, done, ptr_data} !== {5'b00101, 16'h7FFF}) begin errors++; $display("FAIL sbiw_ptr: got %h exp %h", {x_write_en, y_write_en, z_write_en, rd_write_en, done, ptr_data}, {5'b00101, 16'h7FFF}); end
`else
        @(negedge clk);
        checks++; if ({done, flags_valid} !== 2'b11) begin errors++; $display("FAIL sbiw_done: got %b exp 11", {done, flags_valid}); end
`endif
        checks++; if (sreg_flags !== 5'b11000) begin errors++; $display("FAIL sbiw_flags: got %b exp 11000", sreg_flags); end
        @(negedge clk);
`ifndef AXIOMA_REGPAIR_PTR_EN
        checks++; if ({rf[31], rf[30]} !== 16'h7FFF) begin errors++; $display("FAIL sbiw_rf: got %h exp 7FFF", {rf[31], rf[30]}); end
`endif
        preload(4'd2, 16'hBEEF);
        send(2'b00, 4'd2, 4'd2, 16'h0000);
        checks++; if ({rs1_addr, rs2_addr} !== {5'd4, 5'd5}) begin errors++; $display("FAIL movw_read: got %h exp %h", {rs1_addr, rs2_addr}, {5'd4, 5'd5}); end
        repeat (2) @(negedge clk);
        checks++; if ({done, flags_valid, sreg_flags} !== {2'b10, 5'b11000}) begin errors++; $display("FAIL movw_done: got %b exp %b", {done, flags_valid, sreg_flags}, {2'b10, 5'b11000}); end
        @(negedge clk);
        checks++; if ({rf[5], rf[4]} !== 16'hBEEF) begin errors++; $display("FAIL movw_self_rf: got %h exp BEEF", {rf[5], rf[4]}); end
        send(2'b00, 4'd0, 4'd2, 16'h0000);
        repeat (3) @(negedge clk);
        checks++; if ({rf[1], rf[0]} !== 16'hBEEF) begin errors++; $display("FAIL movw_copy_rf: got %h exp BEEF", {rf[1], rf[0]}); end
    endtask

    task automatic test_err_and_busy;
        send(2'b01, 4'd5, 4'd0, 16'd3);
        checks++; if ({err, rd_write_en, busy, cmd_ready} !== 4'b1010) begin errors++; $display("FAIL err_pulse: got %b exp 1010", {err, rd_write_en, busy, cmd_ready}); end
        @(negedge clk);
        checks++; if ({err, cmd_ready, busy} !== 3'b010) begin errors++; $display("FAIL err_after: got %b exp 010", {err, cmd_ready, busy}); end
        // Held cmd_valid: MOVW dst=3 src=2 accepted first, WR16 only after done
        cmd_op = 2'b00; cmd_dst = 4'd3; cmd_src = 4'd2; cmd_imm = 16'h0000; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_op = 2'b11; cmd_dst = 4'd1; cmd_imm = 16'hC3D2;
        checks++; if ({busy, cmd_ready} !== 2'b10) begin errors++; $display("FAIL hold_busy: got %b exp 10", {busy, cmd_ready}); end
        @(negedge clk);
        checks++; if ({rd_write_en, rd_addr, rd_data} !== {1'b1, 5'd6, 8'hEF}) begin errors++; $display("FAIL hold_lo: got %h exp %h", {rd_write_en, rd_addr, rd_data}, {1'b1, 5'd6, 8'hEF}); end
        @(negedge clk);
        checks++; if ({done, cmd_ready, rd_addr, rd_data} !== {2'b10, 5'd7, 8'hBE}) begin errors++; $display("FAIL hold_hi: got %h exp %h", {done, cmd_ready, rd_addr, rd_data}, {2'b10, 5'd7, 8'hBE}); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL hold_ready: got %b exp 1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if ({rd_write_en, rd_addr, rd_data} !== {1'b1, 5'd2, 8'hD2}) begin errors++; $display("FAIL held_wr16_lo: got %h exp %h", {rd_write_en, rd_addr, rd_data}, {1'b1, 5'd2, 8'hD2}); end
        @(negedge clk);
        checks++; if ({done, rd_addr, rd_data} !== {1'b1, 5'd3, 8'hC3}) begin errors++; $display("FAIL held_wr16_hi: got %h exp %h", {done, rd_addr, rd_data}, {1'b1, 5'd3, 8'hC3}); end
        @(negedge clk);
        checks++; if ({rf[7], rf[6], rf[3], rf[2]} !== 32'hBEEF_C3D2) begin errors++; $display("FAIL hold_rf: got %h exp BEEFC3D2", {rf[7], rf[6], rf[3], rf[2]}); end
    endtask

    task automatic test_reset_mid;
        preload(4'd12, 16'h2010);
        send(2'b01, 4'd12, 4'd0, 16'd5);
        @(negedge clk);
        checks++; if (rd_write_en !== 1'b1) begin errors++; $display("FAIL mid_we_before: got %b exp 1", rd_write_en); end
        reset = 1'b1;
        #1;
        checks++; if ({rd_write_en, busy, done, sreg_flags} !== 8'b0) begin errors++; $display("FAIL mid_reset: got %b exp 0", {rd_write_en, busy, done, sreg_flags}); end
        @(negedge clk);
        checks++; if ({rf[25], rf[24]} !== 16'h2010) begin errors++; $display("FAIL mid_rf: got %h exp 2010", {rf[25], rf[24]}); end
        reset = 1'b0;
        send(2'b01, 4'd12, 4'd0, 16'd5);
        repeat (2) @(negedge clk);
        checks++; if ({done, flags_valid, sreg_flags} !== 7'b1100000) begin errors++; $display("FAIL mid_after_done: got %b exp 1100000", {done, flags_valid, sreg_flags}); end
        @(negedge clk);
        checks++; if ({rf[25], rf[24]} !== 16'h2015) begin errors++; $display("FAIL mid_after_rf: got %h exp 2015", {rf[25], rf[24]}); end
    endtask

    initial begin
        test_reset;
        test_adiw_basic;
        test_adiw_wrap;
        test_wr16;
        test_sbiw_movw;
        test_err_and_busy;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axioma_regpair_seq.md
Name: axioma_regpair_seq

Overview:
Sequencer for 16-bit register-pair operations on the 32x8 AVR register file: MOVW, ADIW, SBIW, and WR16. WR16 writes a 16-bit value to a pair, for example a MUL result to R1:R0.
- Accepts one command per valid/ready handshake.
- Reads both bytes through the two read ports, computes the result, and writes it back through the single 8-bit write port as low byte then high byte.
- Emits SREG flags for ADIW/SBIW.
- Sits between the instruction decoder and the register file, driving its rs1/rs2/rd ports while busy.

Parameters:
ADIW_MIN_PAIR, 12, lowest pair index legal for ADIW/SBIW (pair 12 = R25:R24); lower index gives err.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block idle, command accepted when valid&ready
cmd_op  in  2  00 MOVW, 01 ADIW, 10 SBIW, 11 WR16
cmd_dst  in  4  destination pair index; low reg = 2*dst, high reg = 2*dst+1
cmd_src  in  4  source pair index (MOVW only)
cmd_imm  in  16  ADIW/SBIW use [5:0] as K (0..63); WR16 uses all 16 bits
rs1_addr  out  5  register file read port A address
rs1_data  in  8  read port A data
rs2_addr  out  5  read port B address
rs2_data  in  8  read port B data
rd_addr  out  5  write address
rd_data  out  8  write data
rd_write_en  out  1  write strobe
ptr_data  out  16  pointer write data (drives x/y/z_pointer_in)
x_write_en, y_write_en, z_write_en  out  1 each  pointer write strobes
busy  out  1  state != IDLE
done  out  1  1-cycle pulse, final write cycle
err  out  1  1-cycle pulse, illegal command rejected
sreg_flags  out  5  {S,V,N,Z,C}, held until next ADIW/SBIW
flags_valid  out  1  1-cycle pulse with done for ADIW/SBIW

Behaviour:
- Reset (async, active-high) forces the following immediately, including mid-operation (any in-progress write sequence is abandoned):
  - state=IDLE
  - all strobes, done, err, flags_valid, busy = 0
  - rs/rd addresses = 0, rd_data = 0, ptr_data = 0, sreg_flags = 0
  - command latch cleared
- cmd_ready = (state==IDLE) && !reset. A command is latched at the accept edge T.
- State machine: IDLE -> READ -> WR_LO -> WR_HI -> IDLE. WR16 skips READ.
- READ (T+1):
  - rs1_addr=2*p, rs2_addr=2*p+1, where p=src for MOVW and p=dst for ADIW/SBIW.
  - The result is registered at the end of this cycle.
- WR_LO: rd_write_en=1, rd_addr=2*dst, rd_data=res[7:0].
- WR_HI: rd_write_en=1, rd_addr=2*dst+1, rd_data=res[15:8], done=1; flags_valid=1 and sreg_flags updated if ADIW/SBIW.
- Latency, accept to done: 3 cycles (MOVW/ADIW/SBIW), 2 cycles (WR16). Next accept is possible the cycle after done.
- Read ports idle at address 0 outside READ. Reads precede writes, so MOVW with src==dst is a harmless self-copy.
- ADIW arithmetic: R = {Rh,Rl} + K (16-bit modulo).
  - C = !R15 & Rh7; V = !Rh7 & R15.
- SBIW arithmetic: R = {Rh,Rl} - K (16-bit modulo).
  - C = R15 & !Rh7; V = Rh7 & !R15.
- Both ADIW and SBIW: N=R15, Z=(R==0), S=N^V. MOVW/WR16 leave sreg_flags unchanged.
- ADIW/SBIW with dst < ADIW_MIN_PAIR: err pulse at T+1, no register writes, back to IDLE (ready at T+2).
- cmd_valid while busy is ignored (not accepted). Command fields are sampled only at accept.

Optional Feature:
AXIOMA_REGPAIR_PTR_EN:
- Defined: in WR_LO, when dst is 13/14/15 (X/Y/Z pair), the block asserts x/y/z_write_en with ptr_data=res, keeps rd_write_en=0, and pulses done (plus flags) in that cycle. WR_HI is skipped, saving one cycle.
- Undefined: ptr ports are tied 0 and every pair uses two byte writes.

Decomposition:
- Package axioma_regpair_pkg: op codes, state encoding, X_PAIR=13 / Y_PAIR=14 / Z_PAIR=15, flag bit indices.
- Sub-module axioma_regpair_alu: combinational 16-bit add/sub of 6-bit K with S/V/N/Z/C generation.

Test Plan:
1. WR16 dst=0 imm=0x1234 -> T+1 writes R0=0x34, T+2 writes R1=0x12 with done; sreg_flags unchanged.
2. R25:R24=0x00FF, ADIW dst=12 K=1 -> R24=0x00, R25=0x01, done at T+3, flags S0 V0 N0 Z0 C0.
3. R27:R26=0xFFFF, ADIW dst=13 K=1 -> 0x0000, Z=1 C=1 V=0 N=0 S=0. With macro: single-cycle x_write_en, ptr_data=0x0000, done at T+2.
4. R31:R30=0x8000, SBIW dst=15 K=1 -> 0x7FFF, V=1 S=1 N=0 C=0 Z=0. R5:R4=0xBEEF, MOVW dst=2 src=2 -> R4/R5 unchanged, done.
5. ADIW dst=5 -> err at T+1, no rd_write_en, cmd_ready=1 at T+2; cmd_valid held during busy is accepted only after done.
6. Reset asserted during WR_LO of ADIW -> rd_write_en drops in the same cycle, no WR_HI write, flags remain 0; next command after release completes normally.
